// File: rtl/fetch_controller.sv
// fetch_controller
// Instruction fetch front end: a PC register drives the instruction memory
// address, each fetched word is queued with its address in a 2-entry FIFO,
// and the FIFO head is presented to decode through a valid/ready handshake.
// Aligned redirects flush the queue and retarget the PC. A misaligned
// redirect latches a sticky error and parks the block in HALT until reset.
//
// Ports:
//   clk            - sole clock, rising edge
//   rst_n          - synchronous active-low reset
//   imem_addr      - instruction memory address (equals PC)
//   imem_rdata     - instruction word for imem_addr (combinational memory)
//   redirect_valid - branch/jump redirect request
//   redirect_pc    - redirect target
//   halt_req       - stop fetching
//   out_valid      - FIFO head holds an instruction for decode
//   out_ready      - decode accepts the head this cycle
//   out_instr      - head instruction word
//   out_pc         - head instruction address
//   misalign_err   - sticky misaligned-redirect flag
//   fetch_count    - number of instructions accepted by decode (wraps)
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [31:0] pc;
  logic [0:0]  state;
  logic [0:0]  next_state;

  // Second FIFO slot; the head slot is the registered out_* outputs.
  logic        slot1_valid;
  logic [31:0] slot1_pc;
  logic [31:0] slot1_instr;

  logic redirect_ok;
  logic redirect_bad;
  logic pop;
  logic push;

  assign imem_addr = pc;

  // Decode redirect, handshake and fetch enables for this cycle.
  always_comb begin
    redirect_ok  = 1'b0;
    redirect_bad = 1'b0;
    pop          = 1'b0;
    push         = 1'b0;
    // Once the sticky error is set, redirects are no longer honoured.
    if (redirect_valid && !misalign_err) begin
      if (redirect_pc[1:0] == 2'b00) begin
        redirect_ok = 1'b1;
      end else begin
        redirect_bad = 1'b1;
      end
    end else begin
      redirect_ok  = 1'b0;
      redirect_bad = 1'b0;
    end
    // A redirect discards any same-cycle handshake.
    pop = out_valid && out_ready && !redirect_ok && !redirect_bad;
    // Fetch when there is room now or room made by this cycle's pop.
    push = (state == ST_RUN) && !halt_req && !redirect_ok && !redirect_bad &&
           (!slot1_valid || pop);
  end

  // RUN/HALT transitions; redirects outrank halt_req.
  always_comb begin
    next_state = state;
    case (state)
      ST_RUN: begin
        if (redirect_bad) begin
          next_state = ST_HALT;
        end else if (redirect_ok) begin
          next_state = ST_RUN;
        end else if (halt_req) begin
          next_state = ST_HALT;
        end else begin
          next_state = ST_RUN;
        end
      end
      ST_HALT: begin
        if (misalign_err || redirect_bad) begin
          next_state = ST_HALT;
        end else if (redirect_ok) begin
          next_state = ST_RUN;
        end else if (halt_req) begin
          next_state = ST_HALT;
        end else begin
          next_state = ST_RUN;
        end
      end
      default: next_state = ST_RUN;
    endcase
  end

  // PC, state, error flag, delivery counter and the 2-entry FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      state        <= ST_RUN;
      misalign_err <= 1'b0;
      fetch_count  <= 32'd0;
      out_valid    <= 1'b0;
      out_pc       <= 32'd0;
      out_instr    <= 32'd0;
      slot1_valid  <= 1'b0;
      slot1_pc     <= 32'd0;
      slot1_instr  <= 32'd0;
    end else begin
      state <= next_state;

      if (redirect_bad) begin
        misalign_err <= 1'b1;
      end

      if (pop) begin
        fetch_count <= fetch_count + 32'd1;
      end

      // Misaligned redirects leave the PC where it is.
      if (redirect_ok) begin
        pc <= redirect_pc;
      end else if (push) begin
        pc <= pc + 32'd4;
      end

      if (redirect_ok || redirect_bad) begin
        out_valid   <= 1'b0;
        slot1_valid <= 1'b0;
      end else begin
        case ({push, pop})
          2'b11: begin
            if (slot1_valid) begin
              out_pc      <= slot1_pc;
              out_instr   <= slot1_instr;
              slot1_pc    <= pc;
              slot1_instr <= imem_rdata;
            end else begin
              out_pc    <= pc;
              out_instr <= imem_rdata;
            end
          end
          2'b10: begin
            if (!out_valid) begin
              out_valid <= 1'b1;
              out_pc    <= pc;
              out_instr <= imem_rdata;
            end else begin
              slot1_valid <= 1'b1;
              slot1_pc    <= pc;
              slot1_instr <= imem_rdata;
            end
          end
          2'b01: begin
            out_valid   <= slot1_valid;
            out_pc      <= slot1_pc;
            out_instr   <= slot1_instr;
            slot1_valid <= 1'b0;
          end
          default: begin
            out_valid <= out_valid;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller. Inputs change 1 time unit after the
// rising edge and outputs are checked at that same point, i.e. mid-cycle.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        misalign_err;
  logic [31:0] fetch_count;

  int total = 0;
  int bad   = 0;

  fetch_controller #(.RESET_PC(32'h0000_1000)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .misalign_err(misalign_err),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a few fixed words, a filler pattern elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_1000: mem_word = 32'hFFC4_A303;
      32'h0000_1004: mem_word = 32'h0064_A423;
      32'h0000_1008: mem_word = 32'h0000_0013;
      32'h0000_100C: mem_word = 32'hFE42_0AE3;
      default:       mem_word = a ^ 32'hA5A5_0000;
    endcase
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    halt_req = 1'b0; out_ready = 1'b0;
    #1;
    step();
    step();
    // Reset state, still in reset.
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_err", {31'd0, misalign_err}, 32'd0);
    chk("rst_cnt", fetch_count, 32'd0);
    rst_n = 1'b1;
    chk("rst_addr", imem_addr, 32'h0000_1000);

    // Backpressure: queue fills with 0x1000/0x1004 and the PC parks at 0x1008.
    step();
    chk("bp_first_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_first_pc", out_pc, 32'h0000_1000);
    for (int i = 0; i < 4; i++) step();
    chk("bp_addr_hold", imem_addr, 32'h0000_1008);
    chk("bp_head_pc", out_pc, 32'h0000_1000);
    chk("bp_head_instr", out_instr, 32'hFFC4_A303);
    chk("bp_cnt", fetch_count, 32'd0);

    // Release: pop 0x1000 while pushing 0x1008 into the full queue.
    out_ready = 1'b1;
    step();
    chk("rel_pc", out_pc, 32'h0000_1004);
    chk("rel_cnt", fetch_count, 32'd1);
    chk("rel_addr", imem_addr, 32'h0000_100C);

    // Aligned redirect with a live handshake: head dropped, count unchanged.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_100C;
    step();
    redirect_valid = 1'b0;
    chk("rd_addr", imem_addr, 32'h0000_100C);
    chk("rd_valid", {31'd0, out_valid}, 32'd0);
    chk("rd_cnt", fetch_count, 32'd1);
    step();
    chk("rd_tgt_valid", {31'd0, out_valid}, 32'd1);
    chk("rd_tgt_pc", out_pc, 32'h0000_100C);
    chk("rd_tgt_instr", out_instr, 32'hFE42_0AE3);

    // Top-of-address-space wrap.
    out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_addr1", imem_addr, 32'h0000_0000);
    chk("wrap_pc", out_pc, 32'hFFFF_FFFC);
    chk("wrap_instr", out_instr, 32'h5A5A_FFFC);

    // Streaming after reset: consecutive deliveries, two pops counted.
    out_ready = 1'b1;
    do_reset();
    chk("str_addr0", imem_addr, 32'h0000_1000);
    chk("str_valid0", {31'd0, out_valid}, 32'd0);
    step();
    chk("str_pc0", out_pc, 32'h0000_1000);
    step();
    chk("str_pc1", out_pc, 32'h0000_1004);
    chk("str_instr1", out_instr, 32'h0064_A423);
    step();
    chk("str_cnt", fetch_count, 32'd2);

    // Halt pulse with two entries buffered: drain without refilling.
    out_ready = 1'b0;
    do_reset();
    step();
    step();
    chk("halt_full_addr", imem_addr, 32'h0000_1008);
    out_ready = 1'b1; halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    chk("halt_pc1", out_pc, 32'h0000_1004);
    chk("halt_addr1", imem_addr, 32'h0000_1008);
    step();
    chk("halt_empty", {31'd0, out_valid}, 32'd0);
    chk("halt_addr2", imem_addr, 32'h0000_1008);
    chk("halt_cnt", fetch_count, 32'd2);
    step();
    chk("resume_valid", {31'd0, out_valid}, 32'd1);
    chk("resume_pc", out_pc, 32'h0000_1008);
    chk("resume_addr", imem_addr, 32'h0000_100C);

    // Misaligned redirect: sticky error, locked until reset.
    do_reset();
    step();
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_1002;
    step();
    chk("mis_err", {31'd0, misalign_err}, 32'd1);
    chk("mis_valid", {31'd0, out_valid}, 32'd0);
    chk("mis_addr", imem_addr, 32'h0000_1008);
    redirect_pc = 32'h0000_2000;
    step();
    redirect_valid = 1'b0;
    step();
    chk("lock_addr", imem_addr, 32'h0000_1008);
    chk("lock_valid", {31'd0, out_valid}, 32'd0);
    chk("lock_err", {31'd0, misalign_err}, 32'd1);
    chk("lock_cnt", fetch_count, 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("unlock_err", {31'd0, misalign_err}, 32'd0);
    chk("unlock_addr", imem_addr, 32'h0000_1000);
    step();
    chk("unlock_run", out_pc, 32'h0000_1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
